// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick prescaler, 800x525 raster counters, sync/blank decode and per-cell coordinates.
// Define VGA_SYNC_ACTIVE_HIGH_EN for active-high hsync/vsync (default active-low).
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CELL_W    = 160,
  parameter int CELL_H    = 160
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [3:0] cell_col,
  output logic [3:0] cell_row,
  output logic [7:0] cell_x,
  output logic [7:0] cell_y
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [7:0]    cx_q, cx_d, cy_q, cy_d;
  logic [3:0]    col_q, col_d, row_q, row_d;
  logic          div_end, h_end, v_end, line_adv, x_step, y_step, cx_wrap, cy_wrap, h_act, v_act;
  always_comb begin
    div_end  = div_q == DW'(CLK_DIV - 1);
    h_end    = h_q == 10'(H_TOTAL - 1);
    v_end    = v_q == 10'(V_TOTAL - 1);
    line_adv = tick_q & h_end;
    x_step   = tick_q & (h_q < 10'(H_VISIBLE));
    y_step   = line_adv & (v_q < 10'(V_VISIBLE));
    cx_wrap  = cx_q == 8'(CELL_W - 1);
    cy_wrap  = cy_q == 8'(CELL_H - 1);
    div_d    = div_end ? '0 : div_q + 1'b1;
    tick_d   = div_end;
    h_d      = !tick_q ? h_q : h_end ? '0 : h_q + 1'b1;
    v_d      = !line_adv ? v_q : v_end ? '0 : v_q + 1'b1;
    // Offsets clear at end of line/frame, step while visible, and otherwise hold through blanking.
    cx_d     = line_adv ? '0 : x_step ? (cx_wrap ? '0 : cx_q + 1'b1) : cx_q;
    col_d    = line_adv ? '0 : (x_step & cx_wrap) ? col_q + 1'b1 : col_q;
    cy_d     = (line_adv & v_end) ? '0 : y_step ? (cy_wrap ? '0 : cy_q + 1'b1) : cy_q;
    row_d    = (line_adv & v_end) ? '0 : (y_step & cy_wrap) ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end
  assign h_act = (h_q >= 10'(H_VISIBLE + H_FP)) && (h_q <= 10'(H_VISIBLE + H_FP + H_SYNC - 1));
  assign v_act = (v_q >= 10'(V_VISIBLE + V_FP)) && (v_q <= 10'(V_VISIBLE + V_FP + V_SYNC - 1));
`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  assign hsync = h_act;
  assign vsync = v_act;
`else
  assign hsync = ~h_act;
  assign vsync = ~v_act;
`endif
  assign pix_tick    = tick_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign video_on    = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
  assign line_start  = tick_q & (h_q == '0);
  assign frame_start = line_start & (v_q == '0);
  assign cell_col    = col_q;
  assign cell_row    = row_q;
  assign cell_x      = cx_q;
  assign cell_y      = cy_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench on a scaled-down raster (60x37, 16x8 cells) so full frames stay short.
module tb_vga_timing_gen;
  localparam int CD = 4;
  localparam int HV = 40, HF = 4, HS = 8, HB = 8;
  localparam int VV = 30, VF = 2, VS = 2, VB = 3;
  localparam int CW = 16, CH = 8;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  localparam logic SA = 1'b1;
`else
  localparam logic SA = 1'b0;
`endif
  logic       clk, reset_n;
  logic       pix_tick, hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] hcount, vcount;
  logic [3:0] cell_col, cell_row;
  logic [7:0] cell_x, cell_y;
  int checks, errors;
  int ls_cnt, fs_cnt, hs_cnt, vs_cnt;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CELL_W(CW), .CELL_H(CH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .line_start(line_start),
    .frame_start(frame_start), .cell_col(cell_col), .cell_row(cell_row),
    .cell_x(cell_x), .cell_y(cell_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tick"}, 32'(pix_tick), 0);
    chk({tag, "_h"}, 32'(hcount), 0);
    chk({tag, "_v"}, 32'(vcount), 0);
    chk({tag, "_hsync"}, 32'(hsync), 32'(!SA));
    chk({tag, "_vsync"}, 32'(vsync), 32'(!SA));
    chk({tag, "_ls"}, 32'(line_start), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_cells"}, {cell_col, cell_row, cell_x, cell_y}, 0);
  endtask

  // c = number of rising edges since reset release; pixel n advances on the edge after each tick.
  task automatic model_check(input int c);
    int n, eh, ev, mh, mv;
    logic et, els;
    n   = (c - 1) / CD;
    et  = (c % CD) == 0;
    eh  = n % HT;
    ev  = (n / HT) % VT;
    mh  = eh < HV ? eh : HV;
    mv  = ev < VV ? ev : VV;
    els = et && eh == 0;
    chk("tick", 32'(pix_tick), 32'(et));
    chk("hcount", 32'(hcount), 32'(eh));
    chk("vcount", 32'(vcount), 32'(ev));
    chk("hsync", 32'(hsync), (eh >= HV + HF && eh < HV + HF + HS) ? 32'(SA) : 32'(!SA));
    chk("vsync", 32'(vsync), (ev >= VV + VF && ev < VV + VF + VS) ? 32'(SA) : 32'(!SA));
    chk("video_on", 32'(video_on), 32'(eh < HV && ev < VV));
    chk("line_start", 32'(line_start), 32'(els));
    chk("frame_start", 32'(frame_start), 32'(els && ev == 0));
    chk("cell_col", 32'(cell_col), 32'(mh / CW));
    chk("cell_x", 32'(cell_x), 32'(mh % CW));
    chk("cell_row", 32'(cell_row), 32'(mv / CH));
    chk("cell_y", 32'(cell_y), 32'(mv % CH));
  endtask

  initial begin
    checks = 0; errors = 0;
    ls_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("in_reset");
    reset_n = 1'b1;
    for (int c = 1; c <= HT * VT * CD + 20 * HT * CD + 10 * CD + 2; c++) begin
      @(negedge clk);
      model_check(c);
      if (c <= HT * VT * CD) begin
        ls_cnt += int'(line_start);
        fs_cnt += int'(frame_start);
        hs_cnt += int'(pix_tick && hsync == SA);
        vs_cnt += int'(line_start && vsync == SA);
      end
      if (c == 2965) begin
        chk("pt_h21_v12", {22'(hcount), 10'(vcount)}, {22'd21, 10'd12});
        chk("pt_cells", {cell_col, cell_x, cell_row, cell_y}, {4'd1, 8'd5, 4'd1, 8'd4});
      end
      if (c == 3081) chk("pt_held", {cell_col, cell_x, 22'(hcount)}, {4'd2, 8'd8, 22'd50});
    end
    chk("frame_line_starts", 32'(ls_cnt), 32'(VT));
    chk("frame_starts", 32'(fs_cnt), 1);
    chk("hsync_ticks", 32'(hs_cnt), 32'(HS * VT));
    chk("vsync_lines", 32'(vs_cnt), 32'(VS));
    chk("mid_frame_v", 32'(vcount), 20);
    #2 reset_n = 1'b0;
    #1 chk_reset_state("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("held_reset");
    reset_n = 1'b1;
    for (int c = 1; c <= 2 * HT * CD + 5; c++) begin
      @(negedge clk);
      model_check(c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
